// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V integer constants and types
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - combinational register file read port
// Decodes one read index, forces x0 to zero and optionally forwards the in-flight write.
module reg_file_rd_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b0
) (
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] i_regs,
    input  logic                                       i_wen,
    input  logic [ADDR_WIDTH-1:0]                      i_waddr,
    input  logic [DATA_WIDTH-1:0]                      i_wdata,
    input  logic [ADDR_WIDTH-1:0]                      i_raddr,
    output logic [DATA_WIDTH-1:0]                      o_rdata
);
    logic w_zero;
    logic w_hit;

    assign w_zero = (i_raddr == '0);
    assign w_hit  = BYPASS && i_wen && (i_waddr == i_raddr) && (i_waddr != '0);

    always_comb begin
        o_rdata = i_regs[i_raddr];
        if (w_zero) begin
            o_rdata = '0;
        end else if (w_hit) begin
            o_rdata = i_wdata;
        end
    end
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - RISC-V integer register file, 2 read ports, 1 write port
// x0 holds no storage; entry 0 of the read vector is a constant zero.
module reg_file
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter bit BYPASS     = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wen_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata2_o
);
    localparam int NUM = 2 ** ADDR_WIDTH;

    logic [NUM-1:1][DATA_WIDTH-1:0] r_regs;
    logic [NUM-1:0][DATA_WIDTH-1:0] w_regs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_regs <= '0;
        end else if (wen_i) begin
            for (int i = 1; i < NUM; i++) begin
                if (waddr_i == ADDR_WIDTH'(i)) begin
                    r_regs[i] <= wdata_i;
                end
            end
        end
    end

    assign w_regs = {r_regs, {DATA_WIDTH{1'b0}}};

    reg_file_rd_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS    (BYPASS)
    ) u_rd_port1 (
        .i_regs (w_regs),
        .i_wen  (wen_i),
        .i_waddr(waddr_i),
        .i_wdata(wdata_i),
        .i_raddr(raddr1_i),
        .o_rdata(rdata1_o)
    );

    reg_file_rd_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS    (BYPASS)
    ) u_rd_port2 (
        .i_regs (w_regs),
        .i_wen  (wen_i),
        .i_waddr(waddr_i),
        .i_wdata(wdata_i),
        .i_raddr(raddr2_i),
        .o_rdata(rdata2_o)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file (BYPASS=0)
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    logic [31:0] e1;
    logic [31:0] e2;
    int          n_tests = 0;
    int          n_fail  = 0;

    reg_file dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .wen_i   (wen),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr1_i(raddr1),
        .rdata1_o(rdata1),
        .raddr2_i(raddr2),
        .rdata2_o(rdata2)
    );

    always #5 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic drive_read(input logic [4:0] a1, input logic [4:0] a2);
        raddr1 = a1;
        raddr2 = a2;
        exp_q.push_back(model[a1]);
        exp_q.push_back(model[a2]);
    endtask

    task automatic do_write(input logic we, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = we;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        wen = 1'b0;
        if (we && a != 5'd0) model[a] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive_read(5'(i), 5'(31 - i));
            #1;
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            n_tests += 2;
            if (rdata1 !== e1) begin
                n_fail++;
                $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", i, rdata1, e1);
            end
            if (rdata2 !== e2) begin
                n_fail++;
                $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - i, rdata2, e2);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(1'b1, 5'd1, 32'hDEADBEEF);
        drive_read(5'd1, 5'd2);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests += 2;
        if (rdata1 !== e1 || e1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_read_rd1 got=%h exp=%h", rdata1, 32'hDEADBEEF);
        end
        if (rdata2 !== e2) begin
            n_fail++;
            $display("FAIL write_read_rd2 got=%h exp=%h", rdata2, e2);
        end
    endtask

    task automatic test_x0();
        do_write(1'b1, 5'd0, 32'hFFFFFFFF);
        drive_read(5'd0, 5'd0);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests += 2;
        if (rdata1 !== e1) begin
            n_fail++;
            $display("FAIL x0_rd1 got=%h exp=%h", rdata1, e1);
        end
        if (rdata2 !== e2) begin
            n_fail++;
            $display("FAIL x0_rd2 got=%h exp=%h", rdata2, e2);
        end
    endtask

    task automatic test_wen_low();
        do_write(1'b0, 5'd3, 32'h12345678);
        drive_read(5'd3, 5'd1);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests += 2;
        if (rdata1 !== e1) begin
            n_fail++;
            $display("FAIL wen_low_rd1 got=%h exp=%h", rdata1, e1);
        end
        if (rdata2 !== e2) begin
            n_fail++;
            $display("FAIL wen_low_rd2 got=%h exp=%h", rdata2, e2);
        end
    endtask

    task automatic test_all_regs();
        for (int i = 1; i < 32; i++) do_write(1'b1, 5'(i), 32'hA5A50000 | 32'(i));
        for (int i = 0; i < 32; i++) begin
            drive_read(5'(i), 5'(31 - i));
            #1;
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            n_tests += 2;
            if (rdata1 !== e1) begin
                n_fail++;
                $display("FAIL all_regs_rd1 addr=%0d got=%h exp=%h", i, rdata1, e1);
            end
            if (rdata2 !== e2) begin
                n_fail++;
                $display("FAIL all_regs_rd2 addr=%0d got=%h exp=%h", 31 - i, rdata2, e2);
            end
        end
        for (int i = 0; i < 32; i += 5) begin
            drive_read(5'(i), 5'(i));
            #1;
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            n_tests += 2;
            if (rdata1 !== e1) begin
                n_fail++;
                $display("FAIL same_addr_rd1 addr=%0d got=%h exp=%h", i, rdata1, e1);
            end
            if (rdata2 !== e2) begin
                n_fail++;
                $display("FAIL same_addr_rd2 addr=%0d got=%h exp=%h", i, rdata2, e2);
            end
        end
    endtask

    // Without bypass, a read of the register being written shows the old value until the edge.
    task automatic test_back_to_back();
        @(negedge clk);
        wen = 1'b1;
        waddr = 5'd5;
        wdata = 32'hCAFE0005;
        drive_read(5'd5, 5'd6);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests += 2;
        if (rdata1 !== e1) begin
            n_fail++;
            $display("FAIL no_bypass_old got=%h exp=%h", rdata1, e1);
        end
        if (rdata2 !== e2) begin
            n_fail++;
            $display("FAIL no_bypass_other got=%h exp=%h", rdata2, e2);
        end
        @(posedge clk);
        #1;
        model[5] = 32'hCAFE0005;
        waddr = 5'd6;
        wdata = 32'hCAFE0006;
        drive_read(5'd5, 5'd6);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests += 2;
        if (rdata1 !== e1) begin
            n_fail++;
            $display("FAIL b2b_new got=%h exp=%h", rdata1, e1);
        end
        if (rdata2 !== e2) begin
            n_fail++;
            $display("FAIL b2b_pending got=%h exp=%h", rdata2, e2);
        end
        @(posedge clk);
        #1;
        wen = 1'b0;
        model[6] = 32'hCAFE0006;
        drive_read(5'd6, 5'd31);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests += 2;
        if (rdata1 !== e1) begin
            n_fail++;
            $display("FAIL b2b_second got=%h exp=%h", rdata1, e1);
        end
        if (rdata2 !== e2) begin
            n_fail++;
            $display("FAIL b2b_untouched got=%h exp=%h", rdata2, e2);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        raddr1 = 5'd31;
        raddr2 = 5'd1;
        #2;
        rst_n = 1'b0;
        clear_model();
        drive_read(5'd31, 5'd1);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests += 2;
        if (rdata1 !== e1) begin
            n_fail++;
            $display("FAIL async_rst_rd1 got=%h exp=%h", rdata1, e1);
        end
        if (rdata2 !== e2) begin
            n_fail++;
            $display("FAIL async_rst_rd2 got=%h exp=%h", rdata2, e2);
        end
        @(negedge clk);
        wen = 1'b1;
        waddr = 5'd7;
        wdata = 32'h77777777;
        @(posedge clk);
        #1;
        wen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_read(5'd7, 5'd12);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests += 2;
        if (rdata1 !== e1) begin
            n_fail++;
            $display("FAIL rst_write_dropped got=%h exp=%h", rdata1, e1);
        end
        if (rdata2 !== e2) begin
            n_fail++;
            $display("FAIL rst_other_reg got=%h exp=%h", rdata2, e2);
        end
        do_write(1'b1, 5'd7, 32'h0BADF00D);
        drive_read(5'd7, 5'd0);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests += 2;
        if (rdata1 !== e1) begin
            n_fail++;
            $display("FAIL post_rst_write got=%h exp=%h", rdata1, e1);
        end
        if (rdata2 !== e2) begin
            n_fail++;
            $display("FAIL post_rst_x0 got=%h exp=%h", rdata2, e2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_wen_low();
        test_all_regs();
        test_back_to_back();
        test_async_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
